// File: rtl/neuron_layer_seq_pkg.sv
// Shared Q-format constants, FSM encodings, sizing helpers and the tanh table
// used by neuron_layer_seq and its neuron_a datapath.
package neuron_layer_seq_pkg;

    localparam int Q_WIDTH = 32;
    localparam int Q_FBITS = 24;
    localparam logic [Q_WIDTH-1:0] Q_ONE = 32'h0100_0000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Index width that stays legal for a single-entry range.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // tanh(k/8) for k = 0..32, unsigned Q0.16.
    function automatic logic [15:0] tanh_lut(input logic [5:0] k);
        case (k)
            6'd0:    return 16'd0;
            6'd1:    return 16'd8150;
            6'd2:    return 16'd16051;
            6'd3:    return 16'd23485;
            6'd4:    return 16'd30285;
            6'd5:    return 16'd36346;
            6'd6:    return 16'd41625;
            6'd7:    return 16'd46131;
            6'd8:    return 16'd49912;
            6'd9:    return 16'd53038;
            6'd10:   return 16'd55593;
            6'd11:   return 16'd57660;
            6'd12:   return 16'd59320;
            6'd13:   return 16'd60643;
            6'd14:   return 16'd61694;
            6'd15:   return 16'd62524;
            6'd16:   return 16'd63179;
            6'd17:   return 16'd63693;
            6'd18:   return 16'd64096;
            6'd19:   return 16'd64412;
            6'd20:   return 16'd64659;
            6'd21:   return 16'd64852;
            6'd22:   return 16'd65002;
            6'd23:   return 16'd65120;
            6'd24:   return 16'd65212;
            6'd25:   return 16'd65284;
            6'd26:   return 16'd65339;
            6'd27:   return 16'd65383;
            6'd28:   return 16'd65417;
            6'd29:   return 16'd65443;
            6'd30:   return 16'd65464;
            6'd31:   return 16'd65480;
            default: return 16'd65492;
        endcase
    endfunction

endpackage

// File: rtl/neuron_layer_seq_neuron_a.sv
// neuron_a: three-input neuron y = tanh(w.a + b), two enabled register stages
// (products, then sum) followed by a combinational interpolated tanh.
module neuron_a
    import neuron_layer_seq_pkg::*;
#(
    parameter int WIDTH = Q_WIDTH,
    parameter int FBITS = Q_FBITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] a_3,
    input  logic [WIDTH-1:0] w_1,
    input  logic [WIDTH-1:0] w_2,
    input  logic [WIDTH-1:0] w_3,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1) << FBITS;
    localparam logic [WIDTH-1:0] SAT_IN = WIDTH'(4) << FBITS;

    logic [WIDTH-1:0] p1, p2, p3, bias_r, sum;

    function automatic logic [WIDTH-1:0] mult_q(input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] z);
        logic signed [2*WIDTH-1:0] p;
        p = x * z;
        return WIDTH'(p >>> FBITS);
    endfunction

    // Odd-symmetric tanh: linear interpolation on 1/8 steps over [0,4), 1.0 beyond.
    function automatic logic [WIDTH-1:0] tanh_q(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0]  mag;
        logic [WIDTH-1:0]  res;
        logic [4:0]        seg;
        logic [FBITS-4:0]  frac;
        logic [15:0]       lo, hi, interp;
        logic [FBITS+12:0] step;
        mag = x[WIDTH-1] ? (~x + 1'b1) : x;
        seg  = mag[FBITS+1:FBITS-3];
        frac = mag[FBITS-4:0];
        lo   = tanh_lut({1'b0, seg});
        hi   = tanh_lut({1'b0, seg} + 6'd1);
        step = (FBITS+13)'(hi - lo) * (FBITS+13)'(frac);
        interp = lo + 16'(step >> (FBITS-3));
        if (mag >= SAT_IN) res = ONE;
        else               res = WIDTH'(interp) << (FBITS-16);
        return x[WIDTH-1] ? (~res + 1'b1) : res;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            p1     <= '0;
            p2     <= '0;
            p3     <= '0;
            bias_r <= '0;
            sum    <= '0;
        end else if (enable) begin
            p1     <= mult_q(a_1, w_1);
            p2     <= mult_q(a_2, w_2);
            p3     <= mult_q(a_3, w_3);
            bias_r <= b;
            sum    <= p1 + p2 + p3 + bias_r;
        end
    end

    assign y = tanh_q(sum);

endmodule

// File: rtl/neuron_layer_seq.sv
// Dense layer that time-multiplexes one neuron_a over N_NEURON neurons.
// Optional build macro SEQ_PERF_CNT_EN adds the accept-to-result cycle counter.
module neuron_layer_seq
    import neuron_layer_seq_pkg::*;
#(
    parameter int WIDTH    = Q_WIDTH,
    parameter int FBITS    = Q_FBITS,
    parameter int N_NEURON = 4,
    parameter int LAT      = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            a_1,
    input  logic [WIDTH-1:0]            a_2,
    input  logic [WIDTH-1:0]            a_3,
    output logic [idx_w(N_NEURON)-1:0]  w_idx,
    input  logic [WIDTH-1:0]            w_1,
    input  logic [WIDTH-1:0]            w_2,
    input  logic [WIDTH-1:0]            w_3,
    input  logic [WIDTH-1:0]            b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_NEURON*WIDTH-1:0]   y_flat,
    output logic                        busy,
    output logic [15:0]                 perf_cycles
);

    localparam int IW = idx_w(N_NEURON);
    localparam int CW = idx_w(LAT);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_NEURON - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(LAT - 1);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    drain_cnt;
    logic [WIDTH-1:0] a1_r, a2_r, a3_r;
    logic [WIDTH-1:0] y;
    logic             enable;
    logic             accept;
    logic [LAT-1:0]   pipe_v;
    logic [IW-1:0]    pipe_idx [LAT];

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign enable    = (state == S_ISSUE) || (state == S_DRAIN);
    assign w_idx     = idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            a1_r      <= '0;
            a2_r      <= '0;
            a3_r      <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    state <= S_ISSUE;
                    idx   <= '0;
                    a1_r  <= a_1;
                    a2_r  <= a_2;
                    a3_r  <= a_3;
                end
                S_ISSUE: if (idx == LAST_IDX) begin
                    state     <= S_DRAIN;
                    drain_cnt <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
                S_DRAIN: if (drain_cnt == LAST_DRAIN) begin
                    state <= S_DONE;
                end else begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                S_DONE: if (out_ready) begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The result of the neuron issued LAT cycles ago lands in its slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i < LAT; i++) pipe_idx[i] <= '0;
            y_flat <= '0;
        end else begin
            pipe_v[0]   <= (state == S_ISSUE);
            pipe_idx[0] <= idx;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            if (pipe_v[LAT-1]) y_flat[pipe_idx[LAT-1]*WIDTH +: WIDTH] <= y;
        end
    end

    neuron_a #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_neuron (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .a_1    (a1_r),
        .a_2    (a2_r),
        .a_3    (a3_r),
        .w_1    (w_1),
        .w_2    (w_2),
        .w_3    (w_3),
        .b      (b),
        .y      (y)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_cnt;

    // Loading 1 on accept counts the accept cycle, so the DONE value equals the out_valid latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cnt <= '0;
        end else if (accept) begin
            perf_cnt <= 16'd1;
        end else if (enable && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + 1'b1;
        end
    end

    assign perf_cycles = perf_cnt;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Directed bench for neuron_layer_seq: a 4-neuron layer fed by a table ROM and a
// single-neuron instance with fixed weights.
module tb_neuron_layer_seq;
    import neuron_layer_seq_pkg::*;

    localparam int TOL = 32'h0001_0000;
`ifdef SEQ_PERF_CNT_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0]  a_1, a_2, a_3, w_1, w_2, w_3, b;
    logic [1:0]   w_idx;
    logic [127:0] y_flat;
    logic [15:0]  perf_cycles;

    logic         in_valid_s, in_ready_s, out_valid_s, busy_s;
    logic [0:0]   w_idx_s;
    logic [31:0]  y_s;
    logic [15:0]  perf_s;

    logic [31:0]        rom_w1 [4];
    logic [31:0]        rom_w2 [4];
    logic [31:0]        rom_w3 [4];
    logic [31:0]        rom_b  [4];
    logic signed [31:0] exp_y  [4];

    int errors = 0;
    int checks = 0;
    int cyc;

    assign w_1 = rom_w1[w_idx];
    assign w_2 = rom_w2[w_idx];
    assign w_3 = rom_w3[w_idx];
    assign b   = rom_b[w_idx];

    neuron_layer_seq #(.WIDTH(32), .FBITS(24), .N_NEURON(4), .LAT(2)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_1(a_1), .a_2(a_2), .a_3(a_3), .w_idx(w_idx),
        .w_1(w_1), .w_2(w_2), .w_3(w_3), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y_flat(y_flat),
        .busy(busy), .perf_cycles(perf_cycles)
    );

    neuron_layer_seq #(.WIDTH(32), .FBITS(24), .N_NEURON(1), .LAT(2)) u_dut_single (
        .clock(clock), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .a_1(a_1), .a_2(a_2), .a_3(a_3), .w_idx(w_idx_s),
        .w_1(Q_ONE), .w_2(Q_ONE), .w_3(Q_ONE), .b(32'hFF00_0000),
        .out_valid(out_valid_s), .out_ready(out_ready), .y_flat(y_s),
        .busy(busy_s), .perf_cycles(perf_s)
    );

    function automatic logic signed [31:0] q(input real r);
        return $rtoi(r * 16777216.0);
    endfunction

    function automatic logic [31:0] slot(input int k);
        return y_flat[k*32 +: 32];
    endfunction

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] expv, input int tol);
        int d;
        checks++;
        d = got - expv;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic check_slots(input string tag);
        for (int k = 0; k < 4; k++) check($sformatf("%s[%0d]", tag, k), slot(k), exp_y[k], TOL);
    endtask

    task automatic send(input real x1, input real x2, input real x3);
        a_1 = q(x1); a_2 = q(x2); a_3 = q(x3);
        check("send_in_ready", 32'(in_ready), 1, 0);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        c = 1;
        while (!out_valid && c < 40) begin
            @(posedge clock); #1;
            c++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0; out_ready = 1'b0;
        a_1 = '0; a_2 = '0; a_3 = '0;
        for (int k = 0; k < 4; k++) begin
            rom_w1[k] = '0; rom_w2[k] = '0; rom_w3[k] = '0; rom_b[k] = '0; exp_y[k] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 1, 0);
        check("rst_out_valid", 32'(out_valid), 0, 0);
        check("rst_busy", 32'(busy), 0, 0);
        check("rst_w_idx", 32'(w_idx), 0, 0);
        check("rst_perf", 32'(perf_cycles), 0, 0);
        check_slots("rst_y");

        // zero weights
        send(1.0, 1.0, 1.0);
        check("t1_busy", 32'(busy), 1, 0);
        wait_out(cyc);
        check("t1_latency", cyc, 7, 0);
        check_slots("t1_y");
        check("t1_perf", 32'(perf_cycles), PERF_ON ? 7 : 0, 0);
        handshake();
        check("t1_out_valid_clr", 32'(out_valid), 0, 0);
        check("t1_in_ready", 32'(in_ready), 1, 0);

        // per-row bias ramp
        for (int k = 0; k < 4; k++) begin
            rom_w1[k] = q(0.5);
            rom_b[k]  = q(0.25 * k);
        end
        exp_y[0] = q(0.462117); exp_y[1] = q(0.635149);
        exp_y[2] = q(0.761594); exp_y[3] = q(0.848284);
        send(1.0, 0.0, 0.0);
        wait_out(cyc);
        check("t2_latency", cyc, 7, 0);
        check_slots("t2_y");
        check("t2_w_idx_done", 32'(w_idx), 3, 0);

        // hold in DONE with out_ready low, stray in_valid pulses
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a_1 = q(-1.0);
            @(posedge clock); #1;
            check("t3_out_valid", 32'(out_valid), 1, 0);
            check("t3_busy", 32'(busy), 1, 0);
            check($sformatf("t3_y%0d", i % 4), slot(i % 4), exp_y[i % 4], TOL);
        end
        in_valid = 1'b0;
        handshake();
        check("t3_idle_busy", 32'(busy), 0, 0);
        check("t3_out_valid_clr", 32'(out_valid), 0, 0);
        repeat (2) begin @(posedge clock); #1; end
        check("t3_no_accept", 32'(busy), 0, 0);

        // reset in the third ISSUE cycle
        send(1.0, 0.0, 0.0);
        repeat (2) begin @(posedge clock); #1; end
        check("t4_w_idx_c3", 32'(w_idx), 2, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("t4_out_valid", 32'(out_valid), 0, 0);
        check("t4_in_ready", 32'(in_ready), 1, 0);
        check("t4_busy", 32'(busy), 0, 0);
        check("t4_w_idx", 32'(w_idx), 0, 0);
        check("t4_perf", 32'(perf_cycles), 0, 0);
        for (int k = 0; k < 4; k++) check($sformatf("t4_y_clr[%0d]", k), slot(k), 0, 0);
        send(1.0, 0.0, 0.0);
        wait_out(cyc);
        check("t4_rerun_latency", cyc, 7, 0);
        check_slots("t4_rerun_y");
        handshake();

        // back-to-back with out_ready held high
        out_ready = 1'b1;
        send(1.0, 0.0, 0.0);
        wait_out(cyc);
        check("t5a_latency", cyc, 7, 0);
        check_slots("t5a_y");
        in_valid = 1'b1;
        a_1 = q(-1.0); a_2 = '0; a_3 = '0;
        @(posedge clock); #1;
        check("t5_in_ready", 32'(in_ready), 1, 0);
        check("t5_out_valid", 32'(out_valid), 0, 0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("t5b_busy", 32'(busy), 1, 0);
        check("t5b_w_idx", 32'(w_idx), 0, 0);
        exp_y[0] = q(-0.462117); exp_y[1] = q(-0.244919);
        exp_y[2] = q(0.0);       exp_y[3] = q(0.244919);
        wait_out(cyc);
        check("t5b_latency", cyc, 7, 0);
        check_slots("t5b_y");
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("t5_idle", 32'(busy), 0, 0);

        // single-neuron instance
        a_1 = q(0.5); a_2 = q(0.25); a_3 = q(0.25);
        check("t6_in_ready", 32'(in_ready_s), 1, 0);
        in_valid_s = 1'b1;
        @(posedge clock); #1;
        in_valid_s = 1'b0;
        check("t6_busy", 32'(busy_s), 1, 0);
        cyc = 1;
        while (!out_valid_s && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("t6_latency", cyc, 4, 0);
        check("t6_y", y_s, q(0.0), TOL);
        check("t6_w_idx", 32'(w_idx_s), 0, 0);
        check("t6_perf", 32'(perf_s), PERF_ON ? 4 : 0, 0);
        handshake();
        check("t6_out_valid_clr", 32'(out_valid_s), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
